instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter FETCH_W, default 2: instructions accepted per cycle, legal 1..4.
REQ-002 The block SHALL have parameter ISSUE_W, default 2: instructions offered to decode per cycle, legal 1..FETCH_W.
REQ-003 The block SHALL have parameter DEPTH, default 8: entries, power of two, at least 2*FETCH_W.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port fetch_valid, input, 1 bit: the IM fetch group is present.
REQ-007 The block SHALL have port fetch_cnt, input, clog2(FETCH_W+1) bits: number of valid lanes, lanes 0..cnt-1.
REQ-008 The block SHALL have port fetch_instr, input, FETCH_W*32 bits: lane i at bits [32i+31:32i].
REQ-009 The block SHALL have port fetch_pc, input, 32 bits: PC of lane 0; lane i PC = fetch_pc + 4i, mod 2^32.
REQ-010 The block SHALL have port fetch_ready, output, 1 bit: free entries >= FETCH_W.
REQ-011 The block SHALL have port issue_valid, output, ISSUE_W bits: thermometer code, bit i set when entry head+i is occupied.
REQ-012 The block SHALL have port issue_instr, output, ISSUE_W*32 bits: entries head..head+ISSUE_W-1.
REQ-013 The block SHALL have port issue_pc, output, ISSUE_W*32 bits: the PCs matching issue_instr.
REQ-014 The block SHALL have port issue_take, input, clog2(ISSUE_W+1) bits: number of entries consumed by decode this cycle.
REQ-015 The block SHALL have port FREEZE, input, 1 bit: pipeline freeze; while high, issue_take is ignored.
REQ-016 The block SHALL have port flush, input, 1 bit: taken branch or exception; discard all entries.
REQ-017 The block SHALL have port count, output, clog2(DEPTH+1) bits: occupied entries.
REQ-018 The block SHALL have port take_err, output, 1 bit: sticky error flag.

Function
REQ-019 The queue SHALL be a circular buffer; head and tail pointers are log2(DEPTH)+1 bits wide, and the index wraps modulo DEPTH.
REQ-020 An enqueue SHALL occur when fetch_valid=1, fetch_ready=1 and flush=0; it writes fetch_cnt lanes, in lane order, at tail.
REQ-021 If fetch_valid=1 and fetch_ready=0, the group SHALL be dropped with no state change; the fetch stage holds its PC.
REQ-022 fetch_ready, issue_valid, issue_instr, issue_pc and count SHALL be combinational from registered state only.
REQ-023 There SHALL be no bypass: an instruction enqueued at edge N first appears on issue_* after edge N.
REQ-024 The effective take SHALL be take_eff = FREEZE ? 0 : min(issue_take, occupied count among ISSUE_W); head advances by take_eff.
REQ-025 When issue_take exceeds the occupied count, take_err SHALL set and stay set until reset.
REQ-026 A simultaneous enqueue and dequeue SHALL update count as count + fetch_cnt - take_eff; full-to-empty and empty-to-full in one cycle are legal.
REQ-027 Flush SHALL take priority: on that edge head = tail and count = 0, and the same-cycle enqueue and dequeue are discarded.
REQ-028 issue_instr and issue_pc lanes whose issue_valid bit is 0 SHALL read 32'h0.
REQ-029 fetch_cnt=0 with fetch_valid=1 SHALL be a no-op.

Reset
REQ-030 While RESET=0, the block SHALL set head=0, tail=0, count=0, issue_valid=0, take_err=0, and fetch_ready=1.
REQ-031 Storage contents SHALL NOT be reset; they are masked by issue_valid.
REQ-032 A reset asserted mid-operation SHALL discard all entries immediately and asynchronously.
REQ-033 Release of RESET SHALL be synchronised externally; the first enqueue is permitted on the first edge after release.

Structure
REQ-034 The package mips_pkg SHALL hold the instruction and address width constant INSTR_W=32 and a typedef for the {pc, instr} entry.
REQ-035 The block SHALL have one sub-module, fq_ram: a DEPTH x 64 register array with FETCH_W write ports and ISSUE_W read ports.
REQ-036 Pointer arithmetic and control SHALL stay in instr_fetch_queue.

Verification (FETCH_W=2, ISSUE_W=2, DEPTH=8)
REQ-037 Fill: fetch_pc=0x100, cnt=2 for 4 cycles, issue_take=0 -> count=8, fetch_ready=0; issue_pc lanes = 0x100, 0x104.
REQ-038 Wrap: steady fetch cnt=2 with take=2 for 20 cycles -> count stays 2 and the issue_pc sequence is contiguous across the pointer wrap.
REQ-039 Flush: count=6, flush=1 together with fetch cnt=2 and take=2 -> next cycle count=0, issue_valid=00.
REQ-040 Freeze: count=4, FREEZE=1, take=2 for 3 cycles -> count stays 4 and outputs are unchanged.
REQ-041 Over-take: count=1, take=2 -> head advances by 1, take_err=1, which persists until RESET=0.
REQ-042 Async reset: RESET low mid-cycle with count=5 -> count=0 and issue_valid=00 before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and the stored fetch-queue entry for the instruction front end.
package mips_pkg;

    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Fetch-queue storage: DEPTH entries of {pc, instr}, FETCH_W write ports and
// ISSUE_W combinational read ports. Contents are intentionally not reset.
module fq_ram
    import mips_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic      [FETCH_W-1:0]            we,
    input  logic      [FETCH_W-1:0][IDX_W-1:0] waddr,
    input  fq_entry_t [FETCH_W-1:0]            wdata,
    input  logic      [ISSUE_W-1:0][IDX_W-1:0] raddr,
    output fq_entry_t [ISSUE_W-1:0]            rdata
);

    fq_entry_t mem [DEPTH];

    // Write lanes always target distinct consecutive slots, so port order is irrelevant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (we[i]) begin
                mem[waddr[i]] <= wdata[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rdata[i] = mem[raddr[i]];
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupling queue between instruction fetch and decode: multi-lane enqueue at
// tail, multi-lane in-order issue from head, flush and sticky over-take error.
module instr_fetch_queue
    import mips_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    localparam int FC_W   = $clog2(FETCH_W + 1),
    localparam int IT_W   = $clog2(ISSUE_W + 1),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       fetch_valid,
    input  logic [FC_W-1:0]            fetch_cnt,
    input  logic [FETCH_W*INSTR_W-1:0] fetch_instr,
    input  logic [INSTR_W-1:0]         fetch_pc,
    output logic                       fetch_ready,
    output logic [ISSUE_W-1:0]         issue_valid,
    output logic [ISSUE_W*INSTR_W-1:0] issue_instr,
    output logic [ISSUE_W*INSTR_W-1:0] issue_pc,
    input  logic [IT_W-1:0]            issue_take,
    input  logic                       FREEZE,
    input  logic                       flush,
    output logic [CNT_W-1:0]           count,
    output logic                       take_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] used;
    logic [IT_W-1:0]  occ;
    logic [IT_W-1:0]  take_eff;
    logic [FC_W-1:0]  fcnt_eff;
    logic             over_take;
    logic             enq;

    logic      [FETCH_W-1:0]            we;
    logic      [FETCH_W-1:0][IDX_W-1:0] waddr;
    fq_entry_t [FETCH_W-1:0]            wdata;
    logic      [ISSUE_W-1:0][IDX_W-1:0] raddr;
    fq_entry_t [ISSUE_W-1:0]            rdata;

    // The extra pointer bit distinguishes full from empty.
    assign used        = tail - head;
    assign count       = CNT_W'(used);
    assign fetch_ready = (used <= PTR_W'(DEPTH - FETCH_W));

    always_comb begin
        occ       = (used >= PTR_W'(ISSUE_W)) ? IT_W'(ISSUE_W) : IT_W'(used);
        over_take = (issue_take > occ);
        take_eff  = FREEZE ? '0 : (over_take ? occ : issue_take);
        fcnt_eff  = (fetch_cnt > FC_W'(FETCH_W)) ? FC_W'(FETCH_W) : fetch_cnt;
        enq       = fetch_valid && fetch_ready && !flush;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head     <= '0;
            tail     <= '0;
            take_err <= 1'b0;
        end else begin
            if (flush) begin
                head <= tail;
            end else begin
                head <= head + PTR_W'(take_eff);
                if (enq) begin
                    tail <= tail + PTR_W'(fcnt_eff);
                end
            end
            if (over_take && !FREEZE) begin
                take_err <= 1'b1;
            end
        end
    end

    always_comb begin
        we    = '0;
        waddr = '0;
        wdata = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            we[i]          = enq && (FC_W'(i) < fcnt_eff);
            waddr[i]       = IDX_W'(tail + PTR_W'(i));
            wdata[i].pc    = fetch_pc + INSTR_W'(4 * i);
            wdata[i].instr = fetch_instr[INSTR_W*i +: INSTR_W];
        end
    end

    always_comb begin
        raddr       = '0;
        issue_valid = '0;
        issue_instr = '0;
        issue_pc    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            raddr[i]       = IDX_W'(head + PTR_W'(i));
            issue_valid[i] = (used > PTR_W'(i));
            if (issue_valid[i]) begin
                issue_instr[INSTR_W*i +: INSTR_W] = rdata[i].instr;
                issue_pc[INSTR_W*i +: INSTR_W]    = rdata[i].pc;
            end
        end
    end

    fq_ram #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .IDX_W   (IDX_W)
    ) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule
